// File: rtl/usb_eps_arb_pkg.sv
// usb_defs: shared op encodings and source IDs for the endpoint-status arbiter
package usb_defs;
  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR, OP_ZERO} op_e;
  typedef enum logic {SRC_TRANS, SRC_BUS} src_e;
  function automatic op_e trans_op(input logic zero, input logic write, input logic read);
    return zero ? OP_ZERO : write ? OP_WR : read ? OP_RD : OP_NONE;
  endfunction
endpackage

// File: rtl/usb_eps_arb_if.sv
// usb_eps_arb_if: transaction-engine port (eps_*) and bus-side port (bus_*); master drives requests, slave is the arbiter
interface usb_eps_arb_if #(parameter int AW = 8, parameter int DW = 16);
  logic          eps_read_0;
  logic          eps_zero_0;
  logic          eps_write_0;
  logic [AW-1:0] eps_addr_0;
  logic [DW-1:0] eps_wrdata_0;
  logic [DW-1:0] eps_rddata_3;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  modport master (
    output eps_read_0, eps_zero_0, eps_write_0, eps_addr_0, eps_wrdata_0, bus_req, bus_we, bus_addr, bus_wdata,
    input  eps_rddata_3, bus_ack, bus_rdata
  );
  modport slave (
    input  eps_read_0, eps_zero_0, eps_write_0, eps_addr_0, eps_wrdata_0, bus_req, bus_we, bus_addr, bus_wdata,
    output eps_rddata_3, bus_ack, bus_rdata
  );
endinterface

// File: rtl/usb_eps_ram.sv
// usb_eps_ram: AWxDW synchronous RAM, one write/read port, 1-cycle read latency; ports clk, we_i, addr_i, wdata_i, rdata_o
module usb_eps_ram #(parameter int AW = 8, parameter int DW = 16) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/usb_eps_arb.sv
// usb_eps_arb: EP status RAM arbiter, transaction port has absolute priority, bus gets leftover cycles; ports clk, rst_n, io (usb_eps_arb_if.slave)
module usb_eps_arb import usb_defs::*; #(parameter int AW = 8, parameter int DW = 16) (
  input logic           clk,
  input logic           rst_n,
  usb_eps_arb_if.slave  io
);
  op_e           t_op;
  logic          grant;
  logic          s1_valid_q, s1_valid_d, s1_we_q, s1_we_d;
  src_e          s1_src_q, s1_src_d, s2_src_q;
  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic [DW-1:0] s1_wdata_q, s1_wdata_d;
  logic          s2_valid_q, s2_we_q;
  logic          busy_q, busy_d, ack_q, ack_d;
  logic [DW-1:0] ram_rdata, eps_rd_q, eps_rd_d, bus_rd_q, bus_rd_d;
  always_comb begin
    t_op = trans_op(io.eps_zero_0, io.eps_write_0, io.eps_read_0);
    // the ack cycle is excluded so a still-held bus_req is not re-granted
    grant = io.bus_req && t_op == OP_NONE && !busy_q && !ack_q;
    s1_valid_d = t_op != OP_NONE || grant;
    s1_we_d = t_op == OP_NONE ? io.bus_we : t_op != OP_RD;
    s1_src_d = t_op == OP_NONE ? SRC_BUS : SRC_TRANS;
    s1_addr_d = t_op == OP_NONE ? io.bus_addr : io.eps_addr_0;
    s1_wdata_d = t_op == OP_ZERO ? '0 : t_op == OP_WR ? io.eps_wrdata_0 : io.bus_wdata;
    ack_d = s2_valid_q && s2_src_q == SRC_BUS;
    busy_d = (busy_q || grant) && !ack_d;
    bus_rd_d = ack_d && !s2_we_q ? ram_rdata : '0;
    eps_rd_d = s2_valid_q && s2_src_q == SRC_TRANS && !s2_we_q ? ram_rdata : eps_rd_q;
  end
  always_ff @(posedge clk) begin
    s1_we_q <= s1_we_d;
    s1_src_q <= s1_src_d;
    s1_addr_q <= s1_addr_d;
    s1_wdata_q <= s1_wdata_d;
    s2_we_q <= s1_we_q;
    s2_src_q <= s1_src_q;
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      busy_q <= 1'b0;
      ack_q <= 1'b0;
      eps_rd_q <= '0;
      bus_rd_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s1_valid_q;
      busy_q <= busy_d;
      ack_q <= ack_d;
      eps_rd_q <= eps_rd_d;
      bus_rd_q <= bus_rd_d;
    end
  end
  // write enable comes straight from the S1 register, so a write already in S1 still lands on a reset edge
  usb_eps_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk     (clk),
    .we_i    (s1_valid_q && s1_we_q),
    .addr_i  (s1_addr_q),
    .wdata_i (s1_wdata_q),
    .rdata_o (ram_rdata)
  );
  assign io.eps_rddata_3 = eps_rd_q;
  assign io.bus_ack = ack_q;
  assign io.bus_rdata = bus_rd_q;
endmodule

// File: tb/tb_usb_eps_arb.sv
// tb_usb_eps_arb: directed and constrained-random checks of usb_eps_arb against hand-computed values and a memory model
module tb_usb_eps_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  logic [15:0] mem_m [256];
  bit sv [4];
  logic [15:0] sd [4];
  usb_eps_arb_if #(.AW(8), .DW(16)) io ();
  usb_eps_arb #(.AW(8), .DW(16)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic trans(input logic rd, input logic zr, input logic wr, input logic [7:0] a, input logic [15:0] d);
    io.eps_read_0 = rd;
    io.eps_zero_0 = zr;
    io.eps_write_0 = wr;
    io.eps_addr_0 = a;
    io.eps_wrdata_0 = d;
    tick();
    io.eps_read_0 = 1'b0;
    io.eps_zero_0 = 1'b0;
    io.eps_write_0 = 1'b0;
  endtask
  task automatic bus_xfer(input logic we, input logic [7:0] a, input logic [15:0] d, input logic [15:0] exp, input string tag);
    int k;
    io.bus_req = 1'b1;
    io.bus_we = we;
    io.bus_addr = a;
    io.bus_wdata = d;
    k = 0;
    do begin
      tick();
      k++;
      io.bus_addr = ~a;
      io.bus_wdata = ~d;
    end while (!io.bus_ack && k < 10);
    chk({tag, "_lat"}, 32'(k), 32'd3);
    chk({tag, "_rd"}, io.bus_rdata, exp);
    io.bus_req = 1'b0;
    tick();
  endtask
  task automatic reset_mid(input logic we, input logic [7:0] a, input logic [15:0] d, input string tag);
    int acks;
    io.bus_req = 1'b1;
    io.bus_we = we;
    io.bus_addr = a;
    io.bus_wdata = d;
    tick();
    rst_n = 1'b0;
    io.bus_req = 1'b0;
    tick();
    rst_n = 1'b1;
    chk({tag, "_eps0"}, io.eps_rddata_3, 16'h0);
    chk({tag, "_rd0"}, io.bus_rdata, 16'h0);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      acks += int'(io.bus_ack);
      tick();
    end
    chk({tag, "_noack"}, 32'(acks), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int reqs, acks, r;
    logic pend;
    logic [7:0] a, ba;
    logic [15:0] d, bexp;
    io.eps_read_0 = 1'b0;
    io.eps_zero_0 = 1'b0;
    io.eps_write_0 = 1'b0;
    io.eps_addr_0 = '0;
    io.eps_wrdata_0 = '0;
    io.bus_req = 1'b0;
    io.bus_we = 1'b0;
    io.bus_addr = '0;
    io.bus_wdata = '0;
    repeat (3) tick();
    chk("rst_ack", io.bus_ack, 1'b0);
    chk("rst_brd", io.bus_rdata, 16'h0);
    chk("rst_eps", io.eps_rddata_3, 16'h0);
    rst_n = 1'b1;
    tick();
    bus_xfer(1'b1, 8'h12, 16'hBEEF, 16'h0000, "bw12");
    bus_xfer(1'b0, 8'h12, 16'h0000, 16'hBEEF, "br12");
    trans(1'b0, 1'b0, 1'b1, 8'h40, 16'h00A5);
    trans(1'b1, 1'b0, 1'b0, 8'h40, 16'h0000);
    tick();
    chk("wr_rd_40_early", io.eps_rddata_3, 16'h0000);
    tick();
    chk("wr_rd_40", io.eps_rddata_3, 16'h00A5);
    repeat (3) tick();
    chk("eps_hold", io.eps_rddata_3, 16'h00A5);
    bus_xfer(1'b1, 8'h10, 16'h1111, 16'h0000, "bw10");
    bus_xfer(1'b1, 8'h11, 16'h2222, 16'h0000, "bw11");
    for (int i = 0; i < 8; i++) begin
      if (i >= 3) chk($sformatf("b2b_eps%0d", i), io.eps_rddata_3, i == 3 ? 16'h1111 : i == 4 ? 16'h2222 : 16'hBEEF);
      chk($sformatf("b2b_ack%0d", i), io.bus_ack, i == 6);
      chk($sformatf("b2b_brd%0d", i), io.bus_rdata, i == 6 ? 16'h2222 : 16'h0000);
      io.bus_req = i < 6;
      io.bus_we = 1'b0;
      io.bus_addr = 8'h11;
      io.eps_read_0 = i < 3;
      io.eps_addr_0 = 8'h10 + 8'(i);
      tick();
    end
    io.eps_read_0 = 1'b0;
    bus_xfer(1'b1, 8'h20, 16'h5A5A, 16'h0000, "bw20");
    trans(1'b0, 1'b1, 1'b1, 8'h20, 16'hFFFF);
    trans(1'b1, 1'b0, 1'b0, 8'h20, 16'h0000);
    repeat (2) tick();
    chk("zero_pri", io.eps_rddata_3, 16'h0000);
    trans(1'b1, 1'b0, 1'b1, 8'h22, 16'h3333);
    trans(1'b1, 1'b0, 1'b0, 8'h12, 16'h0000);
    tick();
    chk("wr_over_rd", io.eps_rddata_3, 16'h0000);
    tick();
    chk("rd_after", io.eps_rddata_3, 16'hBEEF);
    trans(1'b1, 1'b0, 1'b0, 8'h22, 16'h0000);
    repeat (2) tick();
    chk("wr_pri_data", io.eps_rddata_3, 16'h3333);
    reset_mid(1'b0, 8'h12, 16'h0000, "rstrd");
    bus_xfer(1'b0, 8'h12, 16'h0000, 16'hBEEF, "br12_post");
    reset_mid(1'b1, 8'h30, 16'h7777, "rstwr");
    bus_xfer(1'b0, 8'h30, 16'h0000, 16'h7777, "br30_post");
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = 16'h1000 + 16'(i);
      trans(1'b0, 1'b0, 1'b1, 8'(i), mem_m[i]);
    end
    for (int i = 0; i < 4; i++) begin
      mem_m[8'h80 + i] = 16'hB000 + 16'(i);
      bus_xfer(1'b1, 8'h80 + 8'(i), mem_m[8'h80 + i], 16'h0000, "bwinit");
    end
    reqs = 0;
    acks = 0;
    pend = 1'b0;
    bexp = '0;
    for (int i = 0; i < 4; i++) sv[i] = 1'b0;
    for (int c = 0; c < 310; c++) begin
      bit got;
      got = 1'b0;
      if (sv[c % 4]) begin
        chk("rnd_eps", io.eps_rddata_3, sd[c % 4]);
        sv[c % 4] = 1'b0;
      end
      if (io.bus_ack) begin
        chk("rnd_bus", io.bus_rdata, bexp);
        acks++;
        pend = 1'b0;
        got = 1'b1;
        io.bus_req = 1'b0;
      end
      r = c < 300 ? int'($urandom_range(0, 3)) : 0;
      a = 8'($urandom_range(0, 15));
      d = 16'($urandom);
      io.eps_read_0 = r == 1;
      io.eps_write_0 = r == 2;
      io.eps_zero_0 = r == 3;
      io.eps_addr_0 = a;
      io.eps_wrdata_0 = d;
      if (r == 1) begin
        sv[(c + 3) % 4] = 1'b1;
        sd[(c + 3) % 4] = mem_m[a];
      end else if (r >= 2) mem_m[a] = r == 3 ? 16'h0 : d;
      if (!pend && !got && c < 300 && $urandom_range(0, 2) == 0) begin
        reqs++;
        pend = 1'b1;
        ba = 8'h80 + 8'($urandom_range(0, 3));
        io.bus_req = 1'b1;
        io.bus_we = 1'($urandom_range(0, 1));
        io.bus_addr = ba;
        io.bus_wdata = 16'($urandom);
        bexp = io.bus_we ? 16'h0 : mem_m[ba];
        if (io.bus_we) mem_m[ba] = io.bus_wdata;
      end
      if (c >= 300 && c < 308 && !pend) c = 308;
      tick();
    end
    chk("rnd_acks", 32'(acks), 32'(reqs));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/usb_eps_arb.md
USB_EPS_ARB -- requirements
Module: usb_eps_arb

Interface
REQ-001 Parameter: AW, 8, EP status RAM address width (256 words).
REQ-002 Parameter: DW, 16, EP status RAM data width.
REQ-003 clk  in  1  single clock domain; all logic on rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 eps_read_0  in  1  transaction-engine read request, cycle 0.
REQ-006 eps_zero_0  in  1  transaction-engine write-zero request, cycle 0.
REQ-007 eps_write_0  in  1  transaction-engine write request, cycle 0.
REQ-008 eps_addr_0  in  AW  transaction-engine address.
REQ-009 eps_wrdata_0  in  DW  transaction-engine write data.
REQ-010 eps_rddata_3  out  DW  transaction-engine read data, valid exactly 3 cycles after eps_read_0.
REQ-011 bus_req  in  1  bus-side access request, held until bus_ack.
REQ-012 bus_we  in  1  bus-side write (1) / read (0).
REQ-013 bus_addr  in  AW  bus-side address.
REQ-014 bus_wdata  in  DW  bus-side write data.
REQ-015 bus_ack  out  1  one-cycle completion strobe.
REQ-016 bus_rdata  out  DW  bus-side read data, valid while bus_ack=1, 0 otherwise.

Function
REQ-017 Transaction port SHALL have absolute priority and is never stalled; no backpressure signal exists.
REQ-018 Per-cycle transaction op priority: zero > write > read; only one executes; zero writes all-zero data to eps_addr_0.
REQ-019 Pipeline: S0 request registered into S1 {valid, we, src, addr, wdata}; S1 drives RAM; S2 RAM read data; S3 registered output.
REQ-020 eps_rddata_3 SHALL update only on completion of a transaction-port read and hold its value otherwise.
REQ-021 Bus grant in cycle N when bus_req=1, no transaction op in cycle N, and no bus access in flight (bus_busy=0).
REQ-022 Grant sets bus_busy; bus_ack asserts exactly at N+3; bus_busy clears same cycle; bus_req ignored during ack cycle, re-arbitrated from N+4.
REQ-023 Bus write commits to RAM in N+1; bus_ack at N+3 for writes too, bus_rdata=0.
REQ-024 Bus inputs captured at grant; later changes before ack SHALL NOT affect the access.
REQ-025 Ordering: accesses commit in S0 issue order; a read issued cycle after a write to same address SHALL return new data (RAM write-before-read by pipeline, no bypass needed beyond one-cycle stage).
REQ-026 Bus starvation bound: with transaction port idle, bus_ack within 3 cycles of bus_req rising.
REQ-027 Continuous transaction traffic MAY stall the bus indefinitely; no fairness counter.
REQ-028 At most one access per cycle reaches the RAM; RAM write enable never asserted for reads.

Reset
REQ-029 While rst_n=0: all stage valids, bus_busy, bus_ack cleared; eps_rddata_3, bus_rdata = 0.
REQ-030 Reset mid-access: in-flight ops discarded, no bus_ack issued; a RAM write already committed in S1 remains.
REQ-031 RAM contents not cleared by reset; firmware initialises via bus.

Structure
REQ-032 Op encoding (NONE/RD/WR/ZERO) and source IDs (TRANS/BUS) SHALL reside in shared package usb_defs.
REQ-033 Sub-module usb_eps_ram: AWxDW single-port-write/single-port-read synchronous RAM, 1-cycle read latency, maps to SB_RAM40_4K.
REQ-034 Arbitration, pipeline registers and ack generation in usb_eps_arb itself.

Verification
REQ-035 Bus write 0x12 <- 0xBEEF, idle trans; bus read 0x12 -> bus_ack 3 cycles after grant, bus_rdata=0xBEEF.
REQ-036 Trans write 0x40 <- 0x00A5, next cycle trans read 0x40 -> eps_rddata_3=0x00A5 three cycles later.
REQ-037 bus_req held while trans reads 0x10,0x11,0x12 back-to-back -> grant in 4th cycle, bus_ack 3 cycles after; trans data correct each.
REQ-038 Simultaneous eps_zero_0 and eps_write_0 (0x20, 0xFFFF) -> later read of 0x20 returns 0x0000.
REQ-039 rst_n=0 one cycle after bus grant -> no bus_ack, all outputs 0; next bus read completes normally.
REQ-040 Random mixed traffic vs. reference memory model -> all read data match, every bus_req acked exactly once.
